// File: rtl/sync_model_pkg.sv
// rtl/sync_model_pkg.sv - shared FSM type and index helpers for synchronous stepping stages
package sync_model_pkg;

  localparam int unsigned MAX_GATES = 256;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    CHECK  = 2'd1,
    HAZARD = 2'd2
  } fsm_t;

  // Indices at or beyond n map to an all-zero vector, so an out-of-range
  // selector can never address a gate.
  function automatic logic [MAX_GATES-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_GATES-1:0] v;
    v = '0;
    if (idx < n && idx < MAX_GATES) v = MAX_GATES'(1) << idx;
    return v;
  endfunction

  function automatic int unsigned lowest_set(input logic [MAX_GATES-1:0] vec);
    int unsigned r;
    r = 0;
    for (int i = MAX_GATES - 1; i >= 0; i--) begin
      if (vec[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_checker.sv
// rtl/hazard_checker.sv - flags gates that lost excitation without firing
module hazard_checker
  import sync_model_pkg::*;
#(
  parameter int unsigned N_GATES = 8,
  parameter int unsigned SEL_W   = $clog2(N_GATES)
) (
  input  logic [N_GATES-1:0] excited_q,
  input  logic [N_GATES-1:0] excited,
  output logic               hazard_hit,
  output logic [SEL_W-1:0]   hazard_idx
);

  logic [N_GATES-1:0] disabled_vec;

  always_comb begin
    disabled_vec = excited_q & ~excited;
    hazard_hit   = |disabled_vec;
    hazard_idx   = SEL_W'(lowest_set(MAX_GATES'(disabled_vec)));
  end

endmodule

// File: rtl/gate_state_stepper.sv
// rtl/gate_state_stepper.sv - fires one excited gate per accepted step and checks semimodularity
module gate_state_stepper
  import sync_model_pkg::*;
#(
  parameter int unsigned               N_GATES = 8,
  parameter logic [N_GATES-1:0]        INIT    = '0,
  parameter int unsigned               CNT_W   = 16,
  parameter int unsigned               SEL_W   = $clog2(N_GATES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_GATES-1:0] next_val,
  output logic [N_GATES-1:0] state,
  output logic [N_GATES-1:0] excited,
  input  logic               step_valid,
  input  logic [SEL_W-1:0]   step_sel,
  output logic               step_ready,
  output logic [N_GATES-1:0] fire,
  output logic               reject,
  output logic               hazard,
  output logic [SEL_W-1:0]   hazard_idx,
  output logic               quiescent,
  output logic [CNT_W-1:0]   step_count
);

  typedef logic [N_GATES-1:0] gate_vec_t;

  fsm_t             fsm_q, fsm_d;
  gate_vec_t        state_q, state_d;
  gate_vec_t        excited_q, excited_d;
  gate_vec_t        fire_q, fire_d;
  logic             reject_q, reject_d;
  logic             hazard_q, hazard_d;
  logic [SEL_W-1:0] hazard_idx_q, hazard_idx_d;
  logic [CNT_W-1:0] count_q, count_d;

  gate_vec_t        sel_oh;
  logic             legal;
  logic             hazard_hit;
  logic [SEL_W-1:0] hit_idx;

  hazard_checker #(
    .N_GATES (N_GATES),
    .SEL_W   (SEL_W)
  ) u_hazard_checker (
    .excited_q  (excited_q),
    .excited    (excited),
    .hazard_hit (hazard_hit),
    .hazard_idx (hit_idx)
  );

  assign excited    = state_q ^ next_val;
  assign state      = state_q;
  assign fire       = fire_q;
  assign reject     = reject_q;
  assign hazard     = hazard_q;
  assign hazard_idx = hazard_idx_q;
  assign step_count = count_q;
  assign step_ready = (fsm_q == RUN) && !reset;
  assign quiescent  = (fsm_q == RUN) && (excited == '0);

  // Out-of-range selectors give an empty one-hot, so legality is a single AND.
  assign sel_oh = gate_vec_t'(onehot(32'(step_sel), N_GATES));
  assign legal  = |(excited & sel_oh);

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    excited_d    = excited_q;
    fire_d       = '0;
    reject_d     = 1'b0;
    hazard_d     = hazard_q;
    hazard_idx_d = hazard_idx_q;
    count_d      = count_q;
    case (fsm_q)
      RUN: begin
        if (step_valid) begin
          if (legal) begin
            state_d   = state_q ^ sel_oh;
            fire_d    = sel_oh;
            excited_d = excited & ~sel_oh;
            count_d   = (&count_q) ? count_q : count_q + 1'b1;
            fsm_d     = CHECK;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      CHECK: begin
        if (hazard_hit) begin
          hazard_d     = 1'b1;
          hazard_idx_d = hit_idx;
          fsm_d        = HAZARD;
        end else begin
          fsm_d = RUN;
        end
      end
      HAZARD:  fsm_d = HAZARD;
      default: fsm_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= RUN;
      state_q      <= INIT;
      excited_q    <= '0;
      fire_q       <= '0;
      reject_q     <= 1'b0;
      hazard_q     <= 1'b0;
      hazard_idx_q <= '0;
      count_q      <= '0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      excited_q    <= excited_d;
      fire_q       <= fire_d;
      reject_q     <= reject_d;
      hazard_q     <= hazard_d;
      hazard_idx_q <= hazard_idx_d;
      count_q      <= count_d;
    end
  end

endmodule
